// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, ALU B-select and ALU op codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_WB_ALU = 4'd4,
        ST_MEM_LD = 4'd5,
        ST_WB_MEM = 4'd6,
        ST_MEM_ST = 4'd7,
        ST_BRANCH = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_NAND  = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_ORI   = 4'b0111;
    localparam logic [3:0] OP_SHL   = 4'b1000;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [2:0] ALUB_OPB  = 3'b000;
    localparam logic [2:0] ALUB_ONE  = 3'b001;
    localparam logic [2:0] ALUB_IMM4 = 3'b010;
    localparam logic [2:0] ALUB_IMM5 = 3'b011;
    localparam logic [2:0] ALUB_IMM3 = 3'b100;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NAND = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SHL  = 3'b100;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_LOAD, OP_SUB, OP_STORE, OP_NAND, OP_BZ,
                          OP_OR, OP_ORI, OP_SHL, OP_HALT};
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational control-word decode from state, opcode, Z flag and memory handshake.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [3:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    input  logic       i_timeout,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_mdr_write,
    output logic       o_ab_write,
    output logic       o_aluout_write,
    output logic       o_reg_write,
    output logic       o_addrsel,
    output logic       o_rasel,
    output logic       o_regin,
    output logic       o_alua,
    output logic [2:0] o_alu_b,
    output logic [2:0] o_alu_op,
    output logic       o_halted,
    output logic       o_illegal
);

    always_comb begin
        o_ir_write     = 1'b0;
        o_pc_write     = 1'b0;
        o_mem_read     = 1'b0;
        o_mem_write    = 1'b0;
        o_mdr_write    = 1'b0;
        o_ab_write     = 1'b0;
        o_aluout_write = 1'b0;
        o_reg_write    = 1'b0;
        o_addrsel      = 1'b0;
        o_rasel        = 1'b0;
        o_regin        = 1'b0;
        o_alua         = 1'b0;
        o_alu_b        = ALUB_OPB;
        o_alu_op       = ALU_ADD;
        o_halted       = 1'b0;
        o_illegal      = 1'b0;
        unique case (i_state)
            ST_FETCH: begin
                // Request drops on the timeout cycle so nothing is started as the FSM heads to HALT
                o_mem_read = !i_timeout;
                o_alu_b    = ALUB_ONE;
                o_ir_write = i_mem_ready;
                o_pc_write = i_mem_ready;
            end
            ST_DECODE: begin
                o_ab_write = 1'b1;
                o_illegal  = !is_legal_op(i_opcode);
            end
            ST_EXEC: begin
                o_aluout_write = 1'b1;
                o_alua         = 1'b1;
                case (i_opcode)
                    OP_SUB:  o_alu_op = ALU_SUB;
                    OP_NAND: o_alu_op = ALU_NAND;
                    OP_OR:   o_alu_op = ALU_OR;
                    OP_ORI: begin
                        o_rasel  = 1'b1;
                        o_alu_b  = ALUB_IMM5;
                        o_alu_op = ALU_OR;
                    end
                    OP_SHL: begin
                        o_alu_b  = ALUB_IMM3;
                        o_alu_op = ALU_SHL;
                    end
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            ST_WB_ALU: begin
                o_reg_write = 1'b1;
                o_rasel     = (i_opcode == OP_ORI);
            end
            ST_MEM_LD: begin
                o_addrsel   = 1'b1;
                o_mem_read  = !i_timeout;
                o_mdr_write = i_mem_ready;
            end
            ST_WB_MEM: begin
                o_reg_write = 1'b1;
                o_regin     = 1'b1;
            end
            ST_MEM_ST: begin
                o_addrsel   = 1'b1;
                o_mem_write = !i_timeout;
            end
            ST_BRANCH: begin
                o_alu_b    = ALUB_IMM4;
                o_pc_write = i_zero;
            end
            ST_HALT:  o_halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit: state register, next-state logic and memory wait watchdog.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mdr_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       reg_write,
    output logic       addrsel,
    output logic       rasel,
    output logic       regin,
    output logic       alua,
    output logic [2:0] alu_b,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait;
    logic [7:0] w_wait_next;
    logic       r_bus_err;
    logic       w_mem_state;
    logic       w_timeout;
    logic [3:0] w_opcode;
    logic       w_unused_ir;

    assign w_opcode    = ir[3:0];
    assign w_unused_ir = ^ir[7:4];

    assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEM_LD) || (r_state == ST_MEM_ST);
    assign w_timeout   = w_mem_state && !mem_ready && (r_wait == 8'(WAIT_MAX));
    // Non-memory states hold the counter at zero, so every memory state is entered with a clean count
    assign w_wait_next = (w_mem_state && !mem_ready && !w_timeout) ? r_wait + 8'd1 : 8'd0;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_RST:    w_next = ST_FETCH;
            ST_FETCH:  w_next = w_timeout ? ST_HALT : (mem_ready ? ST_DECODE : ST_FETCH);
            ST_DECODE: begin
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_NAND, OP_OR, OP_ORI, OP_SHL: w_next = ST_EXEC;
                    OP_LOAD:  w_next = ST_MEM_LD;
                    OP_STORE: w_next = ST_MEM_ST;
                    OP_BZ:    w_next = ST_BRANCH;
                    OP_HALT:  w_next = ST_HALT;
                    default:  w_next = ST_FETCH;
                endcase
            end
            ST_EXEC:   w_next = ST_WB_ALU;
            ST_WB_ALU: w_next = ST_FETCH;
            ST_MEM_LD: w_next = w_timeout ? ST_HALT : (mem_ready ? ST_WB_MEM : ST_MEM_LD);
            ST_WB_MEM: w_next = ST_FETCH;
            ST_MEM_ST: w_next = w_timeout ? ST_HALT : (mem_ready ? ST_FETCH : ST_MEM_ST);
            ST_BRANCH: w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RST;
            r_wait    <= 8'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (w_timeout) r_bus_err <= 1'b1;
        end
    end

    ctrl_out_decode u_out_decode (
        .i_state        (r_state),
        .i_opcode       (w_opcode),
        .i_zero         (zero),
        .i_mem_ready    (mem_ready),
        .i_timeout      (w_timeout),
        .o_ir_write     (ir_write),
        .o_pc_write     (pc_write),
        .o_mem_read     (mem_read),
        .o_mem_write    (mem_write),
        .o_mdr_write    (mdr_write),
        .o_ab_write     (ab_write),
        .o_aluout_write (aluout_write),
        .o_reg_write    (reg_write),
        .o_addrsel      (addrsel),
        .o_rasel        (rasel),
        .o_regin        (regin),
        .o_alua         (alua),
        .o_alu_b        (alu_b),
        .o_alu_op       (alu_op),
        .o_halted       (halted),
        .o_illegal      (illegal)
    );

    assign bus_err = r_bus_err;
    assign state   = r_state;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: instruction-level model expands each instruction into expected per-cycle control words.
module tb_ctrl_fsm;

    localparam int WAIT_MAX = 15;

    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC = 4'd3,
                           S_WB_ALU = 4'd4, S_MEM_LD = 4'd5, S_WB_MEM = 4'd6, S_MEM_ST = 4'd7,
                           S_BRANCH = 4'd8, S_HALT = 4'd9;

    typedef struct packed {
        logic       ir_write, pc_write, mem_read, mem_write, mdr_write, ab_write;
        logic       aluout_write, reg_write, addrsel, rasel, regin, alua;
        logic [2:0] alu_b;
        logic [2:0] alu_op;
        logic       halted, illegal;
    } ctl_t;

    typedef struct {
        logic       rdy;
        logic       z;
        logic [7:0] ir;
        logic [3:0] st;
        ctl_t       c;
        logic       be;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ir = 8'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_write, pc_write, mem_read, mem_write, mdr_write, ab_write;
    logic       aluout_write, reg_write, addrsel, rasel, regin, alua;
    logic [2:0] alu_b, alu_op;
    logic       halted, illegal, bus_err;
    logic [3:0] state;
    ctl_t       act;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    assign act = {ir_write, pc_write, mem_read, mem_write, mdr_write, ab_write,
                  aluout_write, reg_write, addrsel, rasel, regin, alua,
                  alu_b, alu_op, halted, illegal};

    ctrl_fsm #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .zero(zero), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write),
        .mdr_write(mdr_write), .ab_write(ab_write), .aluout_write(aluout_write),
        .reg_write(reg_write), .addrsel(addrsel), .rasel(rasel), .regin(regin), .alua(alua),
        .alu_b(alu_b), .alu_op(alu_op), .halted(halted), .illegal(illegal),
        .bus_err(bus_err), .state(state)
    );

    // ---------------- reference model: instruction -> expected cycle list ----------------
    function automatic void push(input logic r, input logic z, input logic [7:0] i,
                                 input logic [3:0] s, input ctl_t c, input logic be);
        ent_t e;
        e.rdy = r; e.z = z; e.ir = i; e.st = s; e.c = c; e.be = be;
        q.push_back(e);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void plan_instr(input logic [7:0] instr, input logic zb, input int wf, input int wm);
        ctl_t       c;
        logic [3:0] op = instr[3:0];
        c = '0; c.mem_read = 1'b1; c.alu_b = 3'b001;
        for (int i = 0; i < wf; i++) push(1'b0, rb(), instr, S_FETCH, c, 1'b0);
        c.ir_write = 1'b1; c.pc_write = 1'b1;
        push(1'b1, rb(), instr, S_FETCH, c, 1'b0);
        c = '0; c.ab_write = 1'b1;
        c.illegal = !(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF});
        push(rb(), rb(), instr, S_DECODE, c, 1'b0);
        if (op inside {4'h0, 4'h2, 4'h4, 4'h6, 4'h7, 4'h8}) begin
            c = '0; c.aluout_write = 1'b1; c.alua = 1'b1;
            case (op)
                4'h2: c.alu_op = 3'b001;
                4'h4: c.alu_op = 3'b010;
                4'h6: c.alu_op = 3'b011;
                4'h7: begin c.rasel = 1'b1; c.alu_b = 3'b011; c.alu_op = 3'b011; end
                4'h8: begin c.alu_b = 3'b100; c.alu_op = 3'b100; end
                default: c.alu_op = 3'b000;
            endcase
            push(rb(), rb(), instr, S_EXEC, c, 1'b0);
            c = '0; c.reg_write = 1'b1; c.rasel = (op == 4'h7);
            push(rb(), rb(), instr, S_WB_ALU, c, 1'b0);
        end else if (op == 4'h1) begin
            c = '0; c.addrsel = 1'b1; c.mem_read = 1'b1;
            for (int i = 0; i < wm; i++) push(1'b0, rb(), instr, S_MEM_LD, c, 1'b0);
            c.mdr_write = 1'b1;
            push(1'b1, rb(), instr, S_MEM_LD, c, 1'b0);
            c = '0; c.reg_write = 1'b1; c.regin = 1'b1;
            push(rb(), rb(), instr, S_WB_MEM, c, 1'b0);
        end else if (op == 4'h3) begin
            c = '0; c.addrsel = 1'b1; c.mem_write = 1'b1;
            for (int i = 0; i < wm; i++) push(1'b0, rb(), instr, S_MEM_ST, c, 1'b0);
            push(1'b1, rb(), instr, S_MEM_ST, c, 1'b0);
        end else if (op == 4'h5) begin
            c = '0; c.alu_b = 3'b010; c.pc_write = zb;
            push(rb(), zb, instr, S_BRANCH, c, 1'b0);
        end else if (op == 4'hF) begin
            c = '0; c.halted = 1'b1;
            for (int i = 0; i < 3; i++) push(rb(), rb(), 8'($urandom), S_HALT, c, 1'b0);
        end
    endfunction

    // ---------------- stimulus drivers (drive + sample only) ----------------
    task automatic tick(input ent_t e, output logic [3:0] st_o, output ctl_t c_o, output logic be_o);
        ir = e.ir; zero = e.z; mem_ready = e.rdy;
        @(negedge clk);
        st_o = state; c_o = act; be_o = bus_err;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ctl_t c; logic [3:0] st; logic be;
        mem_ready = 1'b1; zero = 1'b1; ir = 8'hFF;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({state, act, bus_err} !== {S_RST, 20'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: state=%0d ctl=%h bus_err=%b, expected state=0 ctl=00000 bus_err=0", state, act, bus_err);
        end
        rst_n = 1'b1;
        push(1'b1, 1'b0, 8'b01_10_0000, S_RST, '0, 1'b0);
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL reset_release: state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", st, c, be, e.st, e.c, e.be);
            end
        end
    endtask

    task automatic test_add();
        ctl_t c; logic [3:0] st; logic be;
        plan_instr(8'b01_10_0000, 1'b0, 0, 0);
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL add: state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", st, c, be, e.st, e.c, e.be);
            end
        end
    endtask

    task automatic test_load();
        ctl_t c; logic [3:0] st; logic be;
        plan_instr(8'b00_01_0001, 1'b0, 0, 3);
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL load_wait: state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", st, c, be, e.st, e.c, e.be);
            end
        end
    endtask

    task automatic test_branch();
        ctl_t c; logic [3:0] st; logic be;
        plan_instr(8'b00_00_0101, 1'b1, 1, 0);
        plan_instr(8'b11_01_0101, 1'b0, 0, 0);
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL branch: state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", st, c, be, e.st, e.c, e.be);
            end
        end
    endtask

    task automatic test_ori_shl();
        ctl_t c; logic [3:0] st; logic be;
        plan_instr(8'b10_11_0111, 1'b0, 0, 0);
        plan_instr(8'b01_00_1000, 1'b0, 2, 0);
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL ori_shl: state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", st, c, be, e.st, e.c, e.be);
            end
        end
    endtask

    task automatic test_illegal();
        ctl_t c; logic [3:0] st; logic be;
        int pulses = 0;
        plan_instr(8'b00_00_1010, 1'b0, 0, 0);
        plan_instr(8'b00_00_0000, 1'b0, 0, 0);
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            if (c.illegal) pulses++;
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL illegal: state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", st, c, be, e.st, e.c, e.be);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL illegal_pulse_count: got %0d cycles, expected 1", pulses);
        end
    endtask

    task automatic test_random();
        ctl_t c; logic [3:0] st; logic be;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] instr = 8'($urandom);
            instr[3:0] = 4'($urandom_range(0, 14));
            plan_instr(instr, rb(), $urandom_range(0, 4), $urandom_range(0, 4));
        end
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL random: ir=%h state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", e.ir, st, c, be, e.st, e.c, e.be);
            end
        end
    endtask

    task automatic test_halt();
        ctl_t c; logic [3:0] st; logic be;
        plan_instr(8'b00_00_1111, 1'b0, 1, 0);
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL halt: state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", st, c, be, e.st, e.c, e.be);
            end
        end
    endtask

    task automatic test_timeout();
        ctl_t c; ctl_t f; logic [3:0] st; logic be;
        apply_reset();
        push(1'b0, 1'b0, 8'h00, S_RST, '0, 1'b0);
        f = '0; f.mem_read = 1'b1; f.alu_b = 3'b001;
        for (int i = 0; i < WAIT_MAX; i++) push(1'b0, rb(), 8'h00, S_FETCH, f, 1'b0);
        f.mem_read = 1'b0;
        push(1'b0, rb(), 8'h00, S_FETCH, f, 1'b0);
        c = '0; c.halted = 1'b1;
        for (int i = 0; i < 4; i++) push(rb(), rb(), 8'($urandom), S_HALT, c, 1'b1);
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL timeout: state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", st, c, be, e.st, e.c, e.be);
            end
        end
        apply_reset();
        push(1'b0, 1'b0, 8'h00, S_RST, '0, 1'b0);
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL timeout_clear: state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", st, c, be, e.st, e.c, e.be);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        ctl_t c; logic [3:0] st; logic be;
        ctl_t sc;
        plan_instr(8'b00_10_0011, 1'b0, 0, 0);
        void'(q.pop_back());
        sc = '0; sc.addrsel = 1'b1; sc.mem_write = 1'b1;
        push(1'b0, 1'b0, 8'b00_10_0011, S_MEM_ST, sc, 1'b0);
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL store_pre_reset: state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", st, c, be, e.st, e.c, e.be);
            end
        end
        mem_ready = 1'b0;
        #2;
        checks++;
        if ({state, mem_write} !== {S_MEM_ST, 1'b1}) begin
            errors++;
            $display("FAIL store_held: state=%0d mem_write=%b, expected state=7 mem_write=1", state, mem_write);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, act, bus_err} !== {S_RST, 20'h0, 1'b0}) begin
            errors++;
            $display("FAIL store_async_reset: state=%0d ctl=%h bus_err=%b, expected state=0 ctl=00000 bus_err=0", state, act, bus_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(1'b0, 1'b0, 8'h00, S_RST, '0, 1'b0);
        plan_instr(8'b01_10_0010, 1'b0, 1, 0);
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            tick(e, st, c, be);
            checks++;
            if ({st, c, be} !== {e.st, e.c, e.be}) begin
                errors++;
                $display("FAIL post_reset: state=%0d ctl=%h be=%b, expected state=%0d ctl=%h be=%b", st, c, be, e.st, e.c, e.be);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_load();
        test_branch();
        test_ori_shl();
        test_illegal();
        test_random();
        test_halt();
        test_timeout();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
- Multi-cycle control unit for the 8-bit datapath.
- Sequences fetch/decode/execute/memory/writeback and drives the datapath mux selects (addrsel, rasel, regin, alua, alu_b) plus all register and memory enables.
- Sits directly upstream of the datapath mux layer. Consumes the IR contents, the Z flag and the memory ready handshake.

Parameters:
WAIT_MAX, 15, maximum cycles a memory access may wait for mem_ready before a bus error is raised (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ir  in  8  instruction register contents; [3:0] opcode, [7:6] rA, [5:4] rB; valid from DECODE onward
zero  in  1  Z flag from flag register
mem_ready  in  1  memory completes current read/write this cycle
ir_write  out  1  load IR from memory data
pc_write  out  1  load PC from ALU result
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mdr_write  out  1  load MDR from memory data
ab_write  out  1  latch OpA/OpB from register file
aluout_write  out  1  latch ALU result
reg_write  out  1  register file write
addrsel  out  1  0=PC, 1=OpB as memory address
rasel  out  1  0=IR[7:6], 1=fixed register 01 as write/read index
regin  out  1  0=ALUout, 1=MDR as register write data
alua  out  1  0=PC, 1=OpA as ALU A operand
alu_b  out  3  000 OpB, 001 const 1, 010 Imm4, 011 Imm5, 100 Imm3
alu_op  out  3  000 ADD, 001 SUB, 010 NAND, 011 OR, 100 SHL
halted  out  1  high while in HALT
illegal  out  1  one-cycle pulse in DECODE on an undefined opcode
bus_err  out  1  sticky until reset; WAIT_MAX exceeded
state  out  4  current state encoding (debug)

Behaviour:
- States: RST, FETCH, DECODE, EXEC, WB_ALU, MEM_LD, WB_MEM, MEM_ST, BRANCH, HALT.
- rst_n low: state=RST asynchronously. All outputs are 0, alu_b=000, alu_op=000, bus_err=0, wait counter=0.
- RST: all enables 0. Goes to FETCH next cycle.
- FETCH: mem_read=1, addrsel=0, alua=0, alu_b=001, alu_op=ADD.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; the FSM then moves to DECODE.
  - Otherwise it stays in FETCH and increments the wait counter.
- DECODE: ab_write=1. Next state by opcode:
  - ADD 0000, SUB 0010, NAND 0100, OR 0110, ORI 0111, SHL 1000 -> EXEC
  - LOAD 0001 -> MEM_LD
  - STORE 0011 -> MEM_ST
  - BZ 0101 -> BRANCH
  - HALT 1111 -> HALT
  - Any other opcode: illegal=1 for this cycle, then FETCH (executes as a NOP).
- EXEC: aluout_write=1. Then WB_ALU. Operand selection by opcode:
  - R-type: alua=1, alu_b=000, alu_op per opcode.
  - ORI: alua=1, rasel=1, alu_b=011, alu_op=OR.
  - SHL: alua=1, alu_b=100, alu_op=SHL.
- WB_ALU: reg_write=1, regin=0, rasel=1 for ORI else 0. Then FETCH.
- MEM_LD: addrsel=1, mem_read=1. mdr_write=1 only when mem_ready=1, then WB_MEM. Otherwise hold and count.
- WB_MEM: reg_write=1, regin=1. Then FETCH.
- MEM_ST: addrsel=1, mem_write=1, held until mem_ready=1. Then FETCH.
- BRANCH: alua=0, alu_b=010, alu_op=ADD, pc_write=zero. Then FETCH.
  - The target is relative to the already-incremented PC.
- HALT: halted=1, all enables 0. Exited only by reset.
- Wait counter:
  - Cleared on entry to FETCH/MEM_LD/MEM_ST and whenever mem_ready=1.
  - Counter reaching WAIT_MAX with mem_ready still 0: bus_err=1, next state HALT, no enable asserted that cycle.
- Minimum latencies:
  - R/ORI/SHL: 4 cycles
  - LOAD: 4 cycles
  - STORE: 3 cycles
  - BZ: 3 cycles
  - Each memory wait cycle adds 1.
- Output decode: the state register drives the outputs. Only pc_write (BRANCH, via zero) and the mem_ready-qualified enables depend on inputs.
- Reset asserted mid-access: memory requests drop immediately, with no partial ir/pc/mdr/reg write.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings (RST=0 ... HALT=9)
  - opcode constants
  - ALU_B select codes
  - ALU_OP codes
- Sub-module ctrl_out_decode: combinational decode of state+opcode+zero+mem_ready to all control outputs. ctrl_fsm keeps the state register, next-state logic and wait counter.

Test Plan:
- Reset release, mem_ready=1 always, ir=8'b01_10_0000 (ADD) -> states RST, FETCH, DECODE, EXEC, WB_ALU, FETCH. In EXEC: alua=1, alu_b=000, alu_op=000. In WB_ALU: reg_write=1, regin=0.
- LOAD ir=8'b00_01_0001 with mem_ready low 3 cycles in MEM_LD -> mem_read and addrsel=1 held for 4 cycles. mdr_write=1 only in the ready cycle. WB_MEM has regin=1.
- BZ with zero=1 then zero=0 -> in BRANCH, alu_b=010 and alua=0 both times. pc_write=1 in the first case, 0 in the second.
- ORI ir=xxxx0111 -> rasel=1 in EXEC and WB_ALU, alu_b=011, alu_op=011. SHL ir=xxxx1000 -> alu_b=100, alu_op=100.
- mem_ready held low in FETCH with WAIT_MAX=15 -> bus_err=1 after 15 wait cycles, then HALT with halted=1 and no ir_write. Reset clears both.
- Opcode 1010 -> illegal pulse of exactly 1 cycle in DECODE, then FETCH. Separately, rst_n pulled low mid-MEM_ST -> mem_write=0 immediately and state=RST.
